// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- instruction-memory bus between the fetch stage and imem.
//
// Signals:
//   imem_req    fetch -> imem  request; held with imem_addr until acknowledged
//   imem_addr   fetch -> imem  32-bit address of the requested word
//   imem_ack    imem -> fetch  imem_rdata is valid this cycle
//   imem_rdata  imem -> fetch  returned instruction word
//
// Modports:
//   master  the fetch stage (drives request/address)
//   slave   the instruction memory (drives ack/data)
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with IF/ID output register, one-entry
// skid buffer, redirect squashing and an imem acknowledge watchdog.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   ACK_MAX   consecutive un-acknowledged request cycles before imem_timeout
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   StallD        decode stall; Instr/PC4 are consumed at an edge with StallD=0
//   redirect      taken branch/jump; fetch restarts at redirect_pc
//   redirect_pc   redirect target
//   imem          instruction-memory bus (if_fetch_if.master)
//   Instr, PC4    instruction and its address+4 toward decode
//   instr_valid   Instr/PC4 hold an unconsumed instruction
//   imem_timeout  one-cycle pulse after ACK_MAX cycles without an ack
//
// Build option:
//   IF_FETCH_MISALIGN_EN  when defined, a redirect target with nonzero low
//                         bits parks the stage in HALT (no requests) until
//                         reset. When undefined the low bits are ignored.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned ACK_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    if_fetch_if.master  imem,
    output logic [31:0] Instr,
    output logic [31:0] PC4,
    output logic        instr_valid,
    output logic        imem_timeout
);

    // Watchdog counts 0 .. ACK_MAX-1 and wraps when it fires.
    localparam int CNT_W = (ACK_MAX > 1) ? $clog2(ACK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(ACK_MAX - 1);

`ifdef IF_FETCH_MISALIGN_EN
    typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;
`else
    typedef enum logic {RUN, SQUASH} state_t;
`endif

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      target_reg, target_next;
    logic             req_reg, req_next;
    logic [31:0]      instr_reg, instr_next;
    logic [31:0]      pc4_reg, pc4_next;
    logic             valid_reg, valid_next;
    logic             skid_full_reg, skid_full_next;
    logic [31:0]      skid_instr_reg, skid_instr_next;
    logic [31:0]      skid_pc4_reg, skid_pc4_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    logic             complete;
    logic [31:0]      pc_plus4;
    logic [31:0]      redir_target;
    logic [31:0]      squash_target;

    // A handshake only counts while our own request is up; stray acks are ignored.
    assign complete = req_reg & imem.imem_ack;
    assign pc_plus4 = pc_reg + 32'd4;

`ifdef IF_FETCH_MISALIGN_EN
    // Keep the raw target so misalignment can be detected when it is applied.
    assign redir_target = redirect_pc;
`else
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    // While squashing, a redirect arriving in the same cycle as the ack wins.
    assign squash_target = redirect ? redir_target : target_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        target_next     = target_reg;
        req_next        = req_reg;
        instr_next      = instr_reg;
        pc4_next        = pc4_reg;
        valid_next      = valid_reg;
        skid_full_next  = skid_full_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc4_next   = skid_pc4_reg;

        case (state_reg)
            RUN: begin
                if (redirect) begin
                    valid_next     = 1'b0;
                    skid_full_next = 1'b0;
                    if (req_reg && !imem.imem_ack) begin
                        // Request in flight: keep it on the bus, drop its data later.
                        state_next  = SQUASH;
                        target_next = redir_target;
                    end else begin
`ifdef IF_FETCH_MISALIGN_EN
                        if (|redir_target[1:0]) begin
                            state_next = HALT;
                            req_next   = 1'b0;
                        end else
`endif
                        begin
                            pc_next  = redir_target;
                            req_next = 1'b1;
                        end
                    end
                end else begin
                    if (valid_reg && !StallD) begin
                        // Decode takes the current word; refill skid first, then bus.
                        if (skid_full_reg) begin
                            instr_next     = skid_instr_reg;
                            pc4_next       = skid_pc4_reg;
                            skid_full_next = 1'b0;
                            if (complete) begin
                                skid_instr_next = imem.imem_rdata;
                                skid_pc4_next   = pc_plus4;
                                skid_full_next  = 1'b1;
                            end
                        end else if (complete) begin
                            instr_next = imem.imem_rdata;
                            pc4_next   = pc_plus4;
                        end else begin
                            valid_next = 1'b0;
                        end
                    end else if (!valid_reg) begin
                        if (complete) begin
                            instr_next = imem.imem_rdata;
                            pc4_next   = pc_plus4;
                            valid_next = 1'b1;
                        end
                    end else if (complete) begin
                        // Output slot held by a stalled decode: park the word.
                        skid_instr_next = imem.imem_rdata;
                        skid_pc4_next   = pc_plus4;
                        skid_full_next  = 1'b1;
                    end

                    if (complete) begin
                        pc_next = pc_plus4;
                    end
                    // Only fetch while there is somewhere to put the answer.
                    req_next = ~skid_full_next;
                end
            end

            SQUASH: begin
                valid_next     = 1'b0;
                skid_full_next = 1'b0;
                if (redirect) begin
                    target_next = redir_target;
                end
                if (complete) begin
                    state_next = RUN;
`ifdef IF_FETCH_MISALIGN_EN
                    if (|squash_target[1:0]) begin
                        state_next = HALT;
                        req_next   = 1'b0;
                    end else
`endif
                    begin
                        pc_next  = squash_target;
                        req_next = 1'b1;
                    end
                end
            end

`ifdef IF_FETCH_MISALIGN_EN
            HALT: begin
                req_next       = 1'b0;
                valid_next     = 1'b0;
                skid_full_next = 1'b0;
            end
`endif

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Watchdog: the request stays on the bus; only the pulse reports the stall.
    always_comb begin
        cnt_next     = '0;
        timeout_next = 1'b0;
        if (req_reg && !imem.imem_ack) begin
            if (cnt_reg == CNT_WRAP) begin
                timeout_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            target_reg     <= RESET_PC;
            req_reg        <= 1'b0;
            instr_reg      <= '0;
            pc4_reg        <= RESET_PC;
            valid_reg      <= 1'b0;
            skid_full_reg  <= 1'b0;
            skid_instr_reg <= '0;
            skid_pc4_reg   <= '0;
            cnt_reg        <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            target_reg     <= target_next;
            req_reg        <= req_next;
            instr_reg      <= instr_next;
            pc4_reg        <= pc4_next;
            valid_reg      <= valid_next;
            skid_full_reg  <= skid_full_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc4_reg   <= skid_pc4_next;
            cnt_reg        <= cnt_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign imem.imem_req  = req_reg;
    assign imem.imem_addr = pc_reg;
    assign Instr          = instr_reg;
    assign PC4            = pc4_reg;
    assign instr_valid    = valid_reg;
    assign imem_timeout   = timeout_reg;

endmodule
